// File: rtl/syn_pc_predict.sv
// ============================================================================
// Module      : syn_pc_predict
// Description : Fetch PC register with a direct-mapped BTB of 2-bit counters,
//               branch resolution, mispredict redirect/flush and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module syn_pc_predict #(
  parameter int ADDR_BIT = 10,
  parameter int IDX_BIT  = 4,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                stall,
  output logic [ADDR_BIT-1:0] pc,
  output logic [ADDR_BIT-1:0] pc_4,
  output logic                pred_taken,
  output logic [ADDR_BIT-1:0] pred_target,
  input  logic                res_valid,
  input  logic [ADDR_BIT-1:0] res_pc,
  input  logic                res_taken,
  input  logic [ADDR_BIT-1:0] res_target,
  input  logic                res_pred_taken,
  input  logic [ADDR_BIT-1:0] res_pred_target,
  output logic                flush,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
);

  localparam int                c_entries  = 1 << IDX_BIT;
  localparam int                c_tag_bit  = ADDR_BIT - IDX_BIT;
  localparam logic [ADDR_BIT-1:0] c_reset_pc = ADDR_BIT'(RESET_PC);
  localparam logic [ADDR_BIT-1:0] c_one      = ADDR_BIT'(1);

  logic [ADDR_BIT-1:0]  r_pc;
  logic                 r_valid  [c_entries];
  logic [c_tag_bit-1:0] r_tag    [c_entries];
  logic [ADDR_BIT-1:0]  r_target [c_entries];
  logic [1:0]           r_ctr    [c_entries];
  logic [31:0]          r_stat_branches;
  logic [31:0]          r_stat_mispredicts;

  logic [IDX_BIT-1:0]   w_idx;
  logic [c_tag_bit-1:0] w_tag;
  logic                 w_hit;
  logic [ADDR_BIT-1:0]  w_pc_4;
  logic                 w_pred_taken;
  logic [ADDR_BIT-1:0]  w_pred_target;

  logic [IDX_BIT-1:0]   w_res_idx;
  logic [c_tag_bit-1:0] w_res_tag;
  logic                 w_res_hit;
  logic [ADDR_BIT-1:0]  w_res_fall;
  logic                 w_mispredict;
  logic                 w_update;
  logic [1:0]           w_ctr_inc;
  logic [1:0]           w_ctr_dec;
  logic [ADDR_BIT-1:0]  w_redirect_pc;

  // Fetch-side lookup reads pre-edge contents, so a same-cycle update is invisible here.
  assign w_idx         = r_pc[IDX_BIT-1:0];
  assign w_tag         = r_pc[ADDR_BIT-1:IDX_BIT];
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_pc_4        = r_pc + c_one;
  assign w_pred_taken  = w_hit && r_ctr[w_idx][1];
  assign w_pred_target = w_pred_taken ? r_target[w_idx] : w_pc_4;

  assign w_res_idx     = res_pc[IDX_BIT-1:0];
  assign w_res_tag     = res_pc[ADDR_BIT-1:IDX_BIT];
  assign w_res_hit     = r_valid[w_res_idx] && (r_tag[w_res_idx] == w_res_tag);
  assign w_res_fall    = res_pc + c_one;
  assign w_mispredict  = res_valid &&
                         ((res_taken != res_pred_taken) ||
                          (res_taken && (res_target != res_pred_target)));
  assign w_update      = en && res_valid;
  assign w_redirect_pc = res_taken ? res_target : w_res_fall;

  always_comb begin
    w_ctr_inc = r_ctr[w_res_idx];
    w_ctr_dec = r_ctr[w_res_idx];
    if (r_ctr[w_res_idx] != 2'b11) w_ctr_inc = r_ctr[w_res_idx] + 2'b01;
    if (r_ctr[w_res_idx] != 2'b00) w_ctr_dec = r_ctr[w_res_idx] - 2'b01;
  end

  // Redirect outranks stall so a squashed path never lingers behind a hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= c_reset_pc;
    end else if (en) begin
      if (w_mispredict) begin
        r_pc <= w_redirect_pc;
      end else if (!stall) begin
        r_pc <= w_pred_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_entries; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b00;
      end
    end else if (w_update) begin
      if (w_res_hit) begin
        if (res_taken) begin
          r_ctr[w_res_idx]    <= w_ctr_inc;
          r_target[w_res_idx] <= res_target;
        end else begin
          r_ctr[w_res_idx]    <= w_ctr_dec;
        end
      end else if (res_taken) begin
        // Miss on a taken branch evicts whatever aliased into this slot.
        r_valid[w_res_idx]  <= 1'b1;
        r_tag[w_res_idx]    <= w_res_tag;
        r_target[w_res_idx] <= res_target;
        r_ctr[w_res_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_update) begin
      r_stat_branches <= r_stat_branches + 32'd1;
      if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign pc               = r_pc;
  assign pc_4             = w_pc_4;
  assign pred_taken       = w_pred_taken;
  assign pred_target      = w_pred_target;
  assign flush            = w_mispredict && en;
  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;

endmodule

`default_nettype wire

// File: tb/tb_syn_pc_predict.sv
// ============================================================================
// Module      : tb_syn_pc_predict
// Description : Directed self-checking bench for syn_pc_predict.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_syn_pc_predict;

  logic        clk;
  logic        rst;
  logic        en;
  logic        stall;
  logic [9:0]  pc;
  logic [9:0]  pc_4;
  logic        pred_taken;
  logic [9:0]  pred_target;
  logic        res_valid;
  logic [9:0]  res_pc;
  logic        res_taken;
  logic [9:0]  res_target;
  logic        res_pred_taken;
  logic [9:0]  res_pred_target;
  logic        flush;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int n_tests = 0;
  int n_fail  = 0;

  syn_pc_predict #(.ADDR_BIT(10), .IDX_BIT(4), .RESET_PC(0)) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .stall            (stall),
    .pc               (pc),
    .pc_4             (pc_4),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .res_valid        (res_valid),
    .res_pc           (res_pc),
    .res_taken        (res_taken),
    .res_target       (res_target),
    .res_pred_taken   (res_pred_taken),
    .res_pred_target  (res_pred_target),
    .flush            (flush),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input logic [9:0] p, input logic t, input logic [9:0] tgt,
                         input logic pt, input logic [9:0] ptgt);
    res_valid = 1'b1; res_pc = p; res_taken = t; res_target = tgt;
    res_pred_taken = pt; res_pred_target = ptgt;
    #1;
  endtask

  task automatic clr_res();
    res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
    res_pred_taken = 1'b0; res_pred_target = '0;
  endtask

  task automatic do_reset();
    clr_res(); en = 1'b1; stall = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (pc !== 10'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", pc); end
    n_tests++; if (pc_4 !== 10'd1) begin n_fail++; $display("FAIL reset_pc_4: got %0d want 1", pc_4); end
    n_tests++; if (pred_taken !== 1'b0 || pred_target !== 10'd1) begin n_fail++;
      $display("FAIL reset_pred: got %0b/%0d want 0/1", pred_taken, pred_target); end
    n_tests++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin n_fail++;
      $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts); end
    // Learn entry 0, then reset asynchronously mid-cycle
    set_res(10'd0, 1'b1, 10'd50, 1'b0, 10'd1);
    tick(); clr_res();
    n_tests++; if (pc !== 10'd50) begin n_fail++; $display("FAIL reset_pre_pc: got %0d want 50", pc); end
    rst = 1'b1; #1;
    n_tests++; if (pc !== 10'd0) begin n_fail++; $display("FAIL reset_async_pc: got %0d want 0", pc); end
    n_tests++; if (pred_taken !== 1'b0 || stat_branches !== 32'd0) begin n_fail++;
      $display("FAIL reset_async_state: got %0b/%0d want 0/0", pred_taken, stat_branches); end
    tick(); rst = 1'b0; #1;
    n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_discard: got %0b want 0", pred_taken); end
    tick();
    n_tests++; if (pc !== 10'd1) begin n_fail++; $display("FAIL reset_first_fetch: got %0d want 1", pc); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_tests++; if (pc !== 10'(i) || pred_taken !== 1'b0) begin n_fail++;
        $display("FAIL seq_pc: got %0d/%0b want %0d/0", pc, pred_taken, i); end
    end
    n_tests++; if (stat_branches !== 32'd0) begin n_fail++; $display("FAIL seq_stats: got %0d want 0", stat_branches); end
  endtask

  task automatic test_wrap();
    do_reset();
    set_res(10'd100, 1'b1, 10'd1023, 1'b0, 10'd101);
    n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL wrap_flush: got %0b want 1", flush); end
    tick(); clr_res(); #1;
    n_tests++; if (pc !== 10'd1023 || pc_4 !== 10'd0) begin n_fail++;
      $display("FAIL wrap_pc_4: got %0d/%0d want 1023/0", pc, pc_4); end
    tick();
    n_tests++; if (pc !== 10'd0) begin n_fail++; $display("FAIL wrap_next: got %0d want 0", pc); end
    n_tests++; if (stat_branches !== 32'd1 || stat_mispredicts !== 32'd1) begin n_fail++;
      $display("FAIL wrap_stats: got %0d/%0d want 1/1", stat_branches, stat_mispredicts); end
  endtask

  task automatic test_loop();
    do_reset();
    set_res(10'd8, 1'b1, 10'd4, 1'b0, 10'd9);
    n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL loop_learn_flush: got %0b want 1", flush); end
    tick(); clr_res();
    n_tests++; if (pc !== 10'd4 || stat_mispredicts !== 32'd1) begin n_fail++;
      $display("FAIL loop_learn_pc: got %0d/%0d want 4/1", pc, stat_mispredicts); end
    for (int i = 0; i < 4; i++) tick();
    n_tests++; if (pc !== 10'd8 || pred_taken !== 1'b1 || pred_target !== 10'd4) begin n_fail++;
      $display("FAIL loop_predict: got %0d/%0b/%0d want 8/1/4", pc, pred_taken, pred_target); end
    set_res(10'd8, 1'b1, 10'd4, 1'b1, 10'd4);
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL loop_correct_flush: got %0b want 0", flush); end
    tick(); clr_res();
    n_tests++; if (pc !== 10'd4) begin n_fail++; $display("FAIL loop_follow: got %0d want 4", pc); end
    // First not-taken: counter 3 -> 2, still predicts taken
    set_res(10'd8, 1'b0, 10'd4, 1'b1, 10'd4);
    n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL loop_exit_flush: got %0b want 1", flush); end
    tick();
    n_tests++; if (pc !== 10'd9) begin n_fail++; $display("FAIL loop_exit_pc: got %0d want 9", pc); end
    set_res(10'd50, 1'b1, 10'd8, 1'b0, 10'd51);
    tick(); clr_res(); #1;
    n_tests++; if (pc !== 10'd8 || pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL loop_ctr2: got %0d/%0b want 8/1", pc, pred_taken); end
    // Second not-taken resolved while fetching pc=8: lookup still sees pre-edge entry
    set_res(10'd8, 1'b0, 10'd4, 1'b1, 10'd4);
    n_tests++; if (pred_taken !== 1'b1 || flush !== 1'b1) begin n_fail++;
      $display("FAIL loop_same_cycle: got %0b/%0b want 1/1", pred_taken, flush); end
    tick();
    n_tests++; if (pc !== 10'd9) begin n_fail++; $display("FAIL loop_exit2_pc: got %0d want 9", pc); end
    set_res(10'd50, 1'b1, 10'd8, 1'b0, 10'd51);
    tick(); clr_res(); #1;
    n_tests++; if (pc !== 10'd8 || pred_taken !== 1'b0 || pred_target !== 10'd9) begin n_fail++;
      $display("FAIL loop_ctr1: got %0d/%0b/%0d want 8/0/9", pc, pred_taken, pred_target); end
    n_tests++; if (stat_branches !== 32'd6 || stat_mispredicts !== 32'd5) begin n_fail++;
      $display("FAIL loop_stats: got %0d/%0d want 6/5", stat_branches, stat_mispredicts); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (pc !== 10'd20) begin n_fail++; $display("FAIL stall_hold: got %0d want 20", pc); end
    set_res(10'd30, 1'b1, 10'd40, 1'b0, 10'd31);
    tick(); clr_res();
    n_tests++; if (pc !== 10'd40) begin n_fail++; $display("FAIL stall_redirect: got %0d want 40", pc); end
    tick();
    n_tests++; if (pc !== 10'd40) begin n_fail++; $display("FAIL stall_hold2: got %0d want 40", pc); end
    stall = 1'b0;
    tick();
    n_tests++; if (pc !== 10'd41) begin n_fail++; $display("FAIL stall_release: got %0d want 41", pc); end
  endtask

  task automatic test_en();
    do_reset();
    tick(); tick();
    en = 1'b0;
    set_res(10'd5, 1'b1, 10'd77, 1'b0, 10'd6);
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL en_flush: got %0b want 0", flush); end
    tick(); tick();
    n_tests++; if (pc !== 10'd2) begin n_fail++; $display("FAIL en_pc: got %0d want 2", pc); end
    n_tests++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin n_fail++;
      $display("FAIL en_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts); end
    clr_res(); en = 1'b1;
    tick(); tick(); tick();
    n_tests++; if (pc !== 10'd5 || pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL en_btb: got %0d/%0b want 5/0", pc, pred_taken); end
  endtask

  task automatic test_alias();
    do_reset();
    set_res(10'd3, 1'b1, 10'd30, 1'b0, 10'd4);
    tick();
    set_res(10'd100, 1'b1, 10'd3, 1'b0, 10'd101);
    tick(); clr_res(); #1;
    n_tests++; if (pc !== 10'd3 || pred_taken !== 1'b1 || pred_target !== 10'd30) begin n_fail++;
      $display("FAIL alias_train: got %0d/%0b/%0d want 3/1/30", pc, pred_taken, pred_target); end
    set_res(10'd100, 1'b1, 10'd19, 1'b0, 10'd101);
    tick(); clr_res(); #1;
    n_tests++; if (pc !== 10'd19 || pred_taken !== 1'b0 || pred_target !== 10'd20) begin n_fail++;
      $display("FAIL alias_miss: got %0d/%0b/%0d want 19/0/20", pc, pred_taken, pred_target); end
    set_res(10'd19, 1'b1, 10'd50, 1'b0, 10'd20);
    tick();
    set_res(10'd100, 1'b1, 10'd19, 1'b0, 10'd101);
    tick(); clr_res(); #1;
    n_tests++; if (pc !== 10'd19 || pred_taken !== 1'b1 || pred_target !== 10'd50) begin n_fail++;
      $display("FAIL alias_replace: got %0d/%0b/%0d want 19/1/50", pc, pred_taken, pred_target); end
    set_res(10'd100, 1'b1, 10'd3, 1'b0, 10'd101);
    tick(); clr_res(); #1;
    n_tests++; if (pc !== 10'd3 || pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL alias_evicted: got %0d/%0b want 3/0", pc, pred_taken); end
    set_res(10'd19, 1'b1, 10'd60, 1'b1, 10'd50);
    n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL alias_target_flush: got %0b want 1", flush); end
    tick();
    n_tests++; if (pc !== 10'd60) begin n_fail++; $display("FAIL alias_target_pc: got %0d want 60", pc); end
    set_res(10'd100, 1'b1, 10'd19, 1'b0, 10'd101);
    tick(); clr_res(); #1;
    n_tests++; if (pc !== 10'd19 || pred_target !== 10'd60) begin n_fail++;
      $display("FAIL alias_new_target: got %0d/%0d want 19/60", pc, pred_target); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; stall = 1'b0;
    clr_res();
    test_reset();
    test_sequential();
    test_wrap();
    test_loop();
    test_stall();
    test_en();
    test_alias();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
